mem_port_arbiter: RTL

Shares the single-ported 16-bit data memory between the fetch stage and the memory stage of the 5-stage pipeline. It accepts one outstanding request from each side, grants one at a time, and drives the memory for a fixed multi-cycle access window. It returns read data with a one-cycle done pulse and produces per-requester stall signals that the pipeline uses as its freeze term.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_window_cnt.sv | 35 +++
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/memory-stage port arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arb_window_cnt.sv
// Loadable down-counter timing the memory access window; zero marks the last cycle.
module mem_arb_window_cnt
    import mem_arb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [MEM_ARB_CNT_W-1:0] load_val,
    input  logic                     en,
    output logic                     zero
);

    logic [MEM_ARB_CNT_W-1:0] cnt_q;
    logic [MEM_ARB_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data memory between fetch and memory stage.
// Optional round-robin arbitration: define MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        if_cancel,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [MEM_ARB_CNT_W-1:0] WIN_LOAD = MEM_ARB_CNT_W'(LATENCY - 1);

    arb_state_e  state_q, state_d;
    grant_e      grant_q, grant_d;
    grant_e      pick;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] dm_rdata_q, dm_rdata_d;
    logic        if_done_q, if_done_d;
    logic        dm_done_q, dm_done_d;
    logic        cancel_q, cancel_d;
    logic        cnt_load;
    logic        cnt_en;
    logic        cnt_zero;
    logic        if_ok;
    logic        in_access;

    // A fetch being flushed in the same cycle never competes for the port.
    assign if_ok = if_req & ~if_cancel;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_e last_grant_q, last_grant_d;

    always_comb begin
        pick = dm_req ? GNT_DM : GNT_IF;
        if (dm_req && if_ok) begin
            pick = (last_grant_q == GNT_DM) ? GNT_IF : GNT_DM;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if ((state_q == ACCESS) && cnt_zero) begin
            last_grant_d = grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        pick = dm_req ? GNT_DM : GNT_IF;
    end
`endif

    mem_arb_window_cnt u_window_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WIN_LOAD),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        cancel_d   = cancel_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;

        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                if (dm_req || if_ok) begin
                    grant_d  = pick;
                    cnt_load = 1'b1;
                    state_d  = ACCESS;
                    if (pick == GNT_DM) begin
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                        wr_d    = dm_wr;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        wr_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                cnt_en = 1'b1;
                if ((grant_q == GNT_IF) && if_cancel) begin
                    cancel_d = 1'b1;
                end
                if (cnt_zero) begin
                    state_d = RESP;
                    if (grant_q == GNT_DM) begin
                        if (!wr_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                        dm_done_d = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = ~cancel_q & ~if_cancel;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= GNT_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            cancel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            cancel_q   <= cancel_d;
        end
    end

    assign in_access = (state_q == ACCESS);
    assign mem_en    = in_access;
    assign mem_wr    = in_access & wr_q;
    assign mem_addr  = in_access ? addr_q : '0;
    assign mem_wdata = (in_access && wr_q) ? wdata_q : '0;

    // A flush arriving in the response cycle still kills the fetch completion.
    assign if_done  = if_done_q & ~if_cancel;
    assign dm_done  = dm_done_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

endmodule
